c0_int_ctrl: RTL and testbench

Interrupt and timer controller for coprocessor 0. It owns the Count/Compare timer, synchronizes the external interrupt lines, and builds Cause.IP. It decides when an interrupt request is presented to the decode stage. It sequences that request against exception and ERET commits signalled by the write-back stage, so an interrupt is never re-raised inside the window before Status.EXL updates.

---
 rtl/c0_int_ctrl.sv | 144 ++++++++++++++
 tb/tb_c0_int_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c0_int_ctrl.sv
// rtl/c0_int_ctrl.sv - CP0 Count/Compare timer, interrupt synchronizers, Cause.IP and interrupt request sequencing
module c0_int_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_DIV   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  ext_int,
    input  logic        c0_we,
    input  logic [7:0]  c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic [1:0]  cause_ip_sw,
    input  logic        ex_commit,
    input  logic        eret_commit,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti,
    output logic [7:0]  cause_ip,
    output logic        int_req
);

    // CP0 addresses are {rd, sel}
    localparam logic [7:0] ADDR_COUNT   = {5'd9, 3'd0};
    localparam logic [7:0] ADDR_COMPARE = {5'd11, 3'd0};

    // A divide-by-1 prescaler still needs a 1-bit register so the wrap compare stays well formed
    localparam int             PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(COUNT_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BLOCK = 2'd2
    } state_t;

    logic [PW-1:0] presc_q;
    logic          presc_wrap;
    logic          count_wr;
    logic          compare_wr;
    logic [31:0]   count_inc;
    logic [5:0]    sync_q [SYNC_STAGES];
    logic [5:0]    sync_out;
    logic          pending;
    logic          commit;
    state_t        state;
    logic          holdoff;

    assign count_wr   = c0_we && (c0_addr == ADDR_COUNT);
    assign compare_wr = c0_we && (c0_addr == ADDR_COMPARE);
    assign presc_wrap = (presc_q == PRESC_MAX);
    assign count_inc  = count + 32'd1;
    assign commit     = ex_commit | eret_commit;

    // Prescaler and Count: a Count write restarts the prescaler and beats a coincident increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            count   <= '0;
        end else if (count_wr) begin
            presc_q <= '0;
            count   <= c0_wdata;
        end else if (presc_wrap) begin
            presc_q <= '0;
            count   <= count_inc;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Compare and the sticky timer flag: only an increment can raise ti, only a Compare write clears it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            compare <= '0;
            ti      <= 1'b0;
        end else if (compare_wr) begin
            compare <= c0_wdata;
            ti      <= 1'b0;
        end else if (!count_wr && presc_wrap && (count_inc == compare)) begin
            ti      <= 1'b1;
        end
    end

    // Multi-flop synchronizer chain for the raw external interrupt lines
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign cause_ip = {ti | sync_out[5], sync_out[4:0], cause_ip_sw};
    assign pending  = (|(cause_ip & status_im)) & status_ie & ~status_exl;

    // Request sequencer: commits force a two-cycle holdoff so no request is raised before Status.EXL settles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            holdoff <= 1'b0;
            int_req <= 1'b0;
        end else if (commit) begin
            state   <= ST_BLOCK;
            holdoff <= 1'b1;
            int_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state   <= ST_REQ;
                        int_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!pending) begin
                        state   <= ST_IDLE;
                        int_req <= 1'b0;
                    end
                end
                ST_BLOCK: begin
                    if (holdoff) begin
                        holdoff <= 1'b0;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    holdoff <= 1'b0;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c0_int_ctrl.sv
// tb/tb_c0_int_ctrl.sv - self-checking bench for c0_int_ctrl with a cycle-level behavioural model
module tb_c0_int_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int COUNT_DIV   = 2;
    localparam logic [7:0] A_COUNT   = 8'h48;
    localparam logic [7:0] A_COMPARE = 8'h58;

    logic        clk;
    logic        resetn;
    logic [5:0]  ext_int;
    logic        c0_we;
    logic [7:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  status_im;
    logic [1:0]  cause_ip_sw;
    logic        ex_commit;
    logic        eret_commit;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [7:0]  cause_ip;
    logic        int_req;

    c0_int_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .COUNT_DIV  (COUNT_DIV)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ext_int    (ext_int),
        .c0_we      (c0_we),
        .c0_addr    (c0_addr),
        .c0_wdata   (c0_wdata),
        .status_ie  (status_ie),
        .status_exl (status_exl),
        .status_im  (status_im),
        .cause_ip_sw(cause_ip_sw),
        .ex_commit  (ex_commit),
        .eret_commit(eret_commit),
        .count      (count),
        .compare    (compare),
        .ti         (ti),
        .cause_ip   (cause_ip),
        .int_req    (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: Count advances every COUNT_DIV edges since the last reset or Count write,
    // external lines appear after SYNC_STAGES edges, and a request is allowed only when
    // pending was seen at the edge and no commit occurred at this edge or the two before it.
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_ti;
    logic        m_int_req;
    int          m_since;
    int          m_since_commit;
    logic [5:0]  ext_q[$];

    function automatic logic [7:0] model_cip();
        logic [5:0] s;
        s = ext_q[$];
        return {m_ti | s[5], s[4:0], cause_ip_sw};
    endfunction

    task automatic model_reset();
        m_count        = 32'd0;
        m_compare      = 32'd0;
        m_ti           = 1'b0;
        m_int_req      = 1'b0;
        m_since        = 0;
        m_since_commit = 3;
        ext_q          = {};
        for (int i = 0; i < SYNC_STAGES; i++) ext_q.push_front(6'd0);
    endtask

    task automatic idle_inputs();
        c0_we       = 1'b0;
        c0_addr     = 8'd0;
        c0_wdata    = 32'd0;
        ex_commit   = 1'b0;
        eret_commit = 1'b0;
    endtask

    // Advance the model using the inputs as presented, then take one clock edge
    task automatic tick();
        logic [7:0] cip;
        logic       pend;
        logic       cwr;
        logic       pwr;
        logic       hit;
        cip  = model_cip();
        pend = (|(cip & status_im)) && status_ie && !status_exl;
        if (ex_commit || eret_commit) m_since_commit = 0;
        else if (m_since_commit < 3)  m_since_commit = m_since_commit + 1;
        m_int_req = pend && (m_since_commit >= 3);
        ext_q.push_front(ext_int);
        void'(ext_q.pop_back());
        cwr = c0_we && (c0_addr == A_COUNT);
        pwr = c0_we && (c0_addr == A_COMPARE);
        hit = 1'b0;
        if (cwr) begin
            m_count = c0_wdata;
            m_since = 0;
        end else begin
            m_since = m_since + 1;
            if (m_since % COUNT_DIV == 0) begin
                m_count = m_count + 32'd1;
                hit = (m_count == m_compare);
            end
        end
        if (pwr) begin
            m_compare = c0_wdata;
            m_ti      = 1'b0;
        end else if (hit) begin
            m_ti = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        c0_we    = 1'b1;
        c0_addr  = addr;
        c0_wdata = data;
        tick();
        c0_we    = 1'b0;
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        ext_int     = 6'd0;
        status_ie   = 1'b0;
        status_exl  = 1'b0;
        status_im   = 8'd0;
        cause_ip_sw = 2'b10;
        idle_inputs();
        #2;
        n_total++; if (count !== 32'd0)     begin n_bad++; $display("FAIL reset_count: got %h want 0", count); end
        n_total++; if (compare !== 32'd0)   begin n_bad++; $display("FAIL reset_compare: got %h want 0", compare); end
        n_total++; if (ti !== 1'b0)         begin n_bad++; $display("FAIL reset_ti: got %b want 0", ti); end
        n_total++; if (int_req !== 1'b0)    begin n_bad++; $display("FAIL reset_int_req: got %b want 0", int_req); end
        n_total++; if (cause_ip !== 8'h02)  begin n_bad++; $display("FAIL reset_cause_ip: got %h want 02", cause_ip); end
        @(posedge clk);
        #1;
        resetn      = 1'b1;
        cause_ip_sw = 2'b00;
        model_reset();
    endtask

    task automatic test_free_run();
        repeat (10) tick();
        n_total++; if (count !== 32'd5)  begin n_bad++; $display("FAIL free_run_count: got %0d want 5", count); end
        n_total++; if (count !== m_count) begin n_bad++; $display("FAIL free_run_model: got %0d want %0d", count, m_count); end
        n_total++; if (ti !== 1'b0)      begin n_bad++; $display("FAIL free_run_ti: got %b want 0", ti); end
        n_total++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL free_run_int_req: got %b want 0", int_req); end
    endtask

    task automatic test_timer_match();
        status_im  = 8'h80;
        status_ie  = 1'b1;
        status_exl = 1'b0;
        wr(A_COMPARE, 32'd8);
        wr(A_COUNT, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_total++; if (ti !== 1'b0) begin n_bad++; $display("FAIL timer_early_ti: cycle %0d got %b want 0", i, ti); end
        end
        tick();
        n_total++; if (ti !== 1'b1)      begin n_bad++; $display("FAIL timer_ti_set: got %b want 1", ti); end
        n_total++; if (count !== 32'd8)  begin n_bad++; $display("FAIL timer_count: got %0d want 8", count); end
        n_total++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL timer_req_early: got %b want 0", int_req); end
        tick();
        n_total++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL timer_req: got %b want 1", int_req); end
        wr(A_COMPARE, 32'h0001_0000);
        n_total++; if (ti !== 1'b0)      begin n_bad++; $display("FAIL timer_ti_clear: got %b want 0", ti); end
        n_total++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL timer_req_hold: got %b want 1", int_req); end
        tick();
        n_total++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL timer_req_drop: got %b want 0", int_req); end
    endtask

    task automatic test_ext_int();
        status_im = 8'h10;
        ext_int   = 6'b000100;
        tick();
        n_total++; if (cause_ip[4] !== 1'b0) begin n_bad++; $display("FAIL ext_cause_early: got %b want 0", cause_ip[4]); end
        tick();
        n_total++; if (cause_ip[4] !== 1'b1)     begin n_bad++; $display("FAIL ext_cause: got %b want 1", cause_ip[4]); end
        n_total++; if (cause_ip !== model_cip()) begin n_bad++; $display("FAIL ext_cause_model: got %h want %h", cause_ip, model_cip()); end
        n_total++; if (int_req !== 1'b0)         begin n_bad++; $display("FAIL ext_req_early: got %b want 0", int_req); end
        tick();
        n_total++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL ext_req: got %b want 1", int_req); end
        status_exl = 1'b1;
        tick();
        n_total++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL ext_exl_mask: got %b want 0", int_req); end
    endtask

    task automatic test_holdoff();
        logic exp_seq [8];
        status_exl = 1'b0;
        tick();
        n_total++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL hold_pre: got %b want 1", int_req); end
        ex_commit = 1'b1;
        tick();
        ex_commit = 1'b0;
        n_total++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL hold_k0: got %b want 0", int_req); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++;
            if (int_req !== (i == 3)) begin n_bad++; $display("FAIL hold_k%0d: got %b want %b", i, int_req, (i == 3)); end
        end
        // ERET at k, again at k+2 reloads the holdoff: low through k+4, high after k+5
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            eret_commit = (i == 0) || (i == 2);
            tick();
            n_total++;
            if (int_req !== exp_seq[i]) begin n_bad++; $display("FAIL hold_reload_%0d: got %b want %b", i, int_req, exp_seq[i]); end
        end
        eret_commit = 1'b0;
    endtask

    task automatic test_simultaneous();
        ext_int   = 6'd0;
        status_im = 8'd0;
        wr(A_COMPARE, 32'h0000_1001);
        wr(A_COUNT, 32'h0000_1000);
        tick();
        wr(A_COMPARE, 32'h0000_1001);
        n_total++; if (count !== 32'h1001) begin n_bad++; $display("FAIL sim_match_count: got %h want 1001", count); end
        n_total++; if (ti !== 1'b0)        begin n_bad++; $display("FAIL sim_compare_wins: got %b want 0", ti); end
        wr(A_COUNT, 32'h0000_1001);
        tick();
        n_total++; if (ti !== 1'b0) begin n_bad++; $display("FAIL sim_count_eq_compare: got %b want 0", ti); end
        wr(A_COUNT, 32'hABCD_0000);
        n_total++; if (count !== 32'hABCD_0000) begin n_bad++; $display("FAIL sim_count_wins: got %h want abcd0000", count); end
        tick();
        n_total++; if (count !== 32'hABCD_0000) begin n_bad++; $display("FAIL sim_presc_clear: got %h want abcd0000", count); end
        tick();
        n_total++; if (count !== 32'hABCD_0001) begin n_bad++; $display("FAIL sim_first_inc: got %h want abcd0001", count); end
        wr(A_COMPARE, 32'd7);
        wr(A_COUNT, 32'hFFFF_FFFF);
        tick();
        tick();
        n_total++; if (count !== 32'd0) begin n_bad++; $display("FAIL sim_wrap: got %h want 0", count); end
        n_total++; if (ti !== 1'b0)     begin n_bad++; $display("FAIL sim_wrap_ti: got %b want 0", ti); end
        wr(8'h49, 32'h0000_0055);
        wr(8'h59, 32'h0000_0066);
        n_total++; if (count !== m_count)     begin n_bad++; $display("FAIL sim_other_addr_count: got %h want %h", count, m_count); end
        n_total++; if (compare !== 32'd7)     begin n_bad++; $display("FAIL sim_other_addr_compare: got %h want 7", compare); end
    endtask

    task automatic test_random();
        int sel;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
            status_ie   = ($urandom_range(0, 3) != 0);
            status_exl  = ($urandom_range(0, 3) == 0);
            status_im   = 8'($urandom);
            cause_ip_sw = 2'($urandom);
            ex_commit   = ($urandom_range(0, 15) == 0);
            eret_commit = ($urandom_range(0, 15) == 0);
            c0_we       = ($urandom_range(0, 3) == 0);
            sel         = $urandom_range(0, 3);
            case (sel)
                0: begin
                    c0_addr  = A_COUNT;
                    c0_wdata = ($urandom_range(0, 1) == 0) ? $urandom : m_compare - 32'($urandom_range(0, 3));
                end
                1: begin
                    c0_addr  = A_COMPARE;
                    c0_wdata = m_count + 32'($urandom_range(0, 5));
                end
                2: begin
                    c0_addr  = 8'($urandom);
                    if (c0_addr == A_COUNT || c0_addr == A_COMPARE) c0_addr = c0_addr ^ 8'h01;
                    c0_wdata = $urandom;
                end
                default: begin
                    c0_addr  = A_COMPARE;
                    c0_wdata = $urandom;
                end
            endcase
            tick();
            n_total++; if (count !== m_count)        begin n_bad++; $display("FAIL rand_count @%0d: got %h want %h", cyc, count, m_count); end
            n_total++; if (compare !== m_compare)    begin n_bad++; $display("FAIL rand_compare @%0d: got %h want %h", cyc, compare, m_compare); end
            n_total++; if (ti !== m_ti)              begin n_bad++; $display("FAIL rand_ti @%0d: got %b want %b", cyc, ti, m_ti); end
            n_total++; if (cause_ip !== model_cip()) begin n_bad++; $display("FAIL rand_cause_ip @%0d: got %h want %h", cyc, cause_ip, model_cip()); end
            n_total++; if (int_req !== m_int_req)    begin n_bad++; $display("FAIL rand_int_req @%0d: got %b want %b", cyc, int_req, m_int_req); end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        ext_int    = 6'd0;
        status_im  = 8'h80;
        status_ie  = 1'b1;
        status_exl = 1'b0;
        wr(A_COMPARE, 32'd100);
        wr(A_COUNT, 32'd99);
        tick();
        tick();
        n_total++; if (ti !== 1'b1) begin n_bad++; $display("FAIL async_pre_ti: got %b want 1", ti); end
        tick();
        n_total++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL async_pre_req: got %b want 1", int_req); end
        #3;
        resetn = 1'b0;
        #1;
        n_total++; if (int_req !== 1'b0)  begin n_bad++; $display("FAIL async_int_req: got %b want 0", int_req); end
        n_total++; if (count !== 32'd0)   begin n_bad++; $display("FAIL async_count: got %h want 0", count); end
        n_total++; if (ti !== 1'b0)       begin n_bad++; $display("FAIL async_ti: got %b want 0", ti); end
        n_total++; if (compare !== 32'd0) begin n_bad++; $display("FAIL async_compare: got %h want 0", compare); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_free_run();
        test_timer_match();
        test_ext_int();
        test_holdoff();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
